// File: rtl/comp_column_acc.sv
// -----------------------------------------------------------------------------
// comp_column_acc
//
// Pipelined column compressor for the vedic multiplier datapath. Each accepted
// beat carries one N_IN-bit partial-product column. The ones in it are counted
// in two register stages:
//   S1 : the column is split into 4-bit groups; each group count (0..4) is
//        registered together with in_last and the effective mode.
//   S2 : the group counts are summed. In per-beat mode the sum is the result.
//        In frame mode the sums of all beats in a frame are accumulated with
//        saturation, and a single result is produced on the last beat.
//
// Handshake semantics (both sides):
//   A beat moves across an interface on a rising edge where valid && ready are
//   both high. A producer keeps valid and its payload stable until that edge.
//   in_ready is combinational from S1 occupancy and out_ready, so a full
//   pipeline with out_ready=1 still accepts one beat per cycle.
//
// Parameters:
//   N_IN   column width in bits (multiple of 4, >= 4)
//   ACC_W  accumulator / result width (>= clog2(N_IN+1))
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       0 = per-beat count, 1 = frame accumulate (sampled at frame start)
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready
//   in_bits    column bits
//   in_last    last beat of a frame (ignored in per-beat mode)
//   out_valid  result valid
//   out_ready  result consumed when out_valid && out_ready
//   out_count  per-beat count or saturated frame sum
//   out_ovf    frame sum saturated; qualifies out_count
// -----------------------------------------------------------------------------
module comp_column_acc #(
    parameter int N_IN  = 16,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_bits,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_count,
    output logic             out_ovf
);

    localparam int NG = N_IN / 4;            // number of 4-bit groups
    localparam int CW = $clog2(N_IN + 1);    // width of one column popcount
    localparam int SW = ACC_W + 1;           // accumulate width incl. carry-out

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic                  r_s1_valid;
    logic [NG-1:0][2:0]    r_s1_grp;
    logic                  r_s1_last;
    logic                  r_s1_mode;

    logic                  r_frame_start;    // next accepted beat opens a frame
    logic                  r_frame_mode;     // mode latched at frame start

    logic                  r_out_valid;
    logic [ACC_W-1:0]      r_out_count;
    logic                  r_out_ovf;

    logic [ACC_W-1:0]      r_acc;
    logic                  r_ovf_acc;        // sticky saturation flag for the frame

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    logic                  w_transfer;
    logic                  w_accept;
    logic                  w_consume;
    logic                  w_eff_mode;
    logic [NG-1:0][2:0]    w_grp;
    logic [CW-1:0]         w_pc;
    logic [SW-1:0]         w_sum;
    logic                  w_ovf;
    logic [ACC_W-1:0]      w_sat;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // S1 can move into S2 whenever S2 is empty or is being emptied this edge.
    assign w_transfer = r_s1_valid && (!r_out_valid || out_ready);
    assign in_ready   = !r_s1_valid || w_transfer;
    assign w_accept   = in_valid && in_ready;
    assign w_consume  = r_out_valid && out_ready;

    // The mode pin only matters on the first beat of a frame; later beats
    // follow the latched mode so a mid-frame toggle is harmless.
    assign w_eff_mode = r_frame_start ? mode : r_frame_mode;

    // ------------------------------------------------------------------
    // Stage 1 combinational: per-group popcount
    // ------------------------------------------------------------------
    always_comb begin
        w_grp = '0;
        for (int g = 0; g < NG; g++) begin
            for (int b = 0; b < 4; b++) begin
                w_grp[g] = w_grp[g] + {2'b00, in_bits[4*g + b]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: sum of groups and saturating accumulate
    // ------------------------------------------------------------------
    always_comb begin
        w_pc = '0;
        for (int g = 0; g < NG; g++) begin
            w_pc = w_pc + CW'(r_s1_grp[g]);
        end
    end

    // One extra bit catches the carry that signals saturation.
    assign w_sum = SW'(r_acc) + SW'(w_pc);
    assign w_ovf = w_sum[ACC_W];
    assign w_sat = w_ovf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

    // ------------------------------------------------------------------
    // Stage 1 registers and frame tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_grp      <= '0;
            r_s1_last     <= 1'b0;
            r_s1_mode     <= 1'b0;
            r_frame_start <= 1'b1;
            r_frame_mode  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_valid    <= 1'b1;
                r_s1_grp      <= w_grp;
                // in_last has no meaning for per-beat counts, so drop it here.
                r_s1_last     <= in_last && w_eff_mode;
                r_s1_mode     <= w_eff_mode;
                r_frame_mode  <= w_eff_mode;
                // A frame stays open only after a frame-mode beat without last.
                r_frame_start <= !w_eff_mode || in_last;
            end else if (w_transfer) begin
                r_s1_valid    <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 registers: output holding register and accumulator
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
            r_acc       <= '0;
            r_ovf_acc   <= 1'b0;
        end else begin
            // A consume frees the slot; a transfer below may refill it on
            // the same edge, which overrides this clear.
            if (w_consume) begin
                r_out_valid <= 1'b0;
            end

            if (w_transfer) begin
                if (!r_s1_mode) begin
                    r_out_count <= ACC_W'(w_pc);
                    r_out_ovf   <= 1'b0;
                    r_out_valid <= 1'b1;
                end else if (r_s1_last) begin
                    r_out_count <= w_sat;
                    r_out_ovf   <= r_ovf_acc | w_ovf;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_ovf_acc   <= 1'b0;
                end else begin
                    r_acc       <= w_sat;
                    r_ovf_acc   <= r_ovf_acc | w_ovf;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_comp_column_acc.sv
// -----------------------------------------------------------------------------
// tb_comp_column_acc
//
// Self-checking bench for comp_column_acc (N_IN=16, ACC_W=8). A monitor on the
// falling edge observes both handshakes: every accepted beat is fed to a
// frame-level reference model (popcount, frame sum, min(sum, 255)) that pushes
// the expected result into exp_q; every consumed result is compared with the
// head of exp_q and logged in got_q for the directed scenario checks.
// -----------------------------------------------------------------------------
module tb_comp_column_acc;

    localparam int N_IN  = 16;
    localparam int ACC_W = 8;
    localparam int MAXV  = (1 << ACC_W) - 1;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic             clk;
    logic             rst_n;
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_bits;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_count;
    logic             out_ovf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    comp_column_acc #(.N_IN(N_IN), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    logic [ACC_W:0] exp_q[$];   // {ovf, count}
    logic [ACC_W:0] got_q[$];
    bit             m_in_frame;
    int             m_total;
    int             n_accept;
    int             n_push;
    int             n_out;
    bit             ready_rand;
    bit             prev_stall;
    logic [ACC_W:0] prev_out;

    task automatic model_accept(input logic [N_IN-1:0] bits, input logic last, input logic md);
        int pop;
        pop = $countones(bits);
        n_accept++;
        if (!m_in_frame && !md) begin
            exp_q.push_back({1'b0, ACC_W'(pop)});
            n_push++;
        end else begin
            m_total += pop;
            if (last) begin
                if (m_total > MAXV) exp_q.push_back({1'b1, ACC_W'(MAXV)});
                else                exp_q.push_back({1'b0, ACC_W'(m_total)});
                n_push++;
                m_in_frame = 1'b0;
                m_total    = 0;
            end else begin
                m_in_frame = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_data", {out_ovf, out_count}, prev_out);
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_ovf, out_count};
            if (out_valid && out_ready) begin
                n_out++;
                got_q.push_back({out_ovf, out_count});
                check_eq("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check_eq("out_data", {out_ovf, out_count}, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                model_accept(in_bits, in_last, mode);
            end
        end else begin
            exp_q.delete();
            m_in_frame = 1'b0;
            m_total    = 0;
            prev_stall = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (ready_rand) out_ready = 1'($urandom_range(0, 1));
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [N_IN-1:0] bits, input logic last, input logic md);
        bit done;
        done     = 1'b0;
        in_bits  = bits;
        in_last  = last;
        mode     = md;
        in_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                break;
            end
        end
        if (done) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_eq("send_accepted", done, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) begin
            @(negedge clk);
        end
        check_eq("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges and checks outputs respond without a clock.
    task automatic pulse_reset();
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_count", out_count, 0);
        check_eq("rst_out_ovf", out_ovf, 0);
        check_eq("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_hold_valid", out_valid, 0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_bits = '0; in_last = 1'b0;
        out_ready = 1'b1; ready_rand = 1'b0;
        m_in_frame = 1'b0; m_total = 0; n_accept = 0; n_push = 0; n_out = 0;
        prev_stall = 1'b0; prev_out = '0;
        #1;
        check_eq("init_out_valid", out_valid, 0);
        check_eq("init_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Per-beat streaming and pipeline timing
        got_q.delete();
        send_beat(16'hFFFF, 1'b0, 1'b0);
        check_eq("lat_after_accept", out_valid, 0);
        send_beat(16'h0001, 1'b0, 1'b0);
        check_eq("lat_first_valid", out_valid, 1);
        check_eq("lat_first_count", out_count, 16);
        send_beat(16'hA5A5, 1'b0, 1'b0);
        check_eq("stream_second", out_count, 1);
        @(posedge clk);
        #1;
        check_eq("stream_third", out_count, 8);
        drain();
        check_eq("stream_n", got_q.size(), 3);
        check_eq("stream_0", got_q[0], {1'b0, 8'd16});
        check_eq("stream_1", got_q[1], {1'b0, 8'd1});
        check_eq("stream_2", got_q[2], {1'b0, 8'd8});

        // Frame accumulate with mid-frame mode toggling
        got_q.delete();
        send_beat(16'hFFFF, 1'b0, 1'b1);
        check_eq("frame_quiet_1", out_valid, 0);
        send_beat(16'h000F, 1'b0, 1'b0);
        check_eq("frame_quiet_2", out_valid, 0);
        send_beat(16'h0000, 1'b0, 1'b0);
        check_eq("frame_quiet_3", out_valid, 0);
        send_beat(16'h8001, 1'b1, 1'b0);
        drain();
        check_eq("frame_n", got_q.size(), 1);
        check_eq("frame_sum", got_q[0], {1'b0, 8'd22});

        // Saturation then a clean single-beat frame
        got_q.delete();
        for (int i = 0; i < 16; i++) send_beat(16'hFFFF, 1'b0, 1'b1);
        send_beat(16'hFFFF, 1'b1, 1'b1);
        send_beat(16'h0003, 1'b1, 1'b1);
        drain();
        check_eq("sat_n", got_q.size(), 2);
        check_eq("sat_value", got_q[0], {1'b1, 8'd255});
        check_eq("sat_next_frame", got_q[1], {1'b0, 8'd2});

        // Backpressure: with out_ready low only two beats fit
        begin
            int snap;
            got_q.delete();
            snap = n_accept;
            out_ready = 1'b0;
            fork
                begin
                    send_beat(16'h0007, 1'b0, 1'b0);
                    send_beat(16'h00FF, 1'b0, 1'b0);
                    send_beat(16'hF0F0, 1'b0, 1'b0);
                end
            join_none
            repeat (6) @(posedge clk);
            #1;
            check_eq("bp_accepted", n_accept - snap, 2);
            check_eq("bp_in_ready", in_ready, 0);
            check_eq("bp_out_held", out_count, 3);
            out_ready = 1'b1;
            wait fork;
            drain();
            check_eq("bp_n", got_q.size(), 3);
            check_eq("bp_0", got_q[0], {1'b0, 8'd3});
            check_eq("bp_1", got_q[1], {1'b0, 8'd8});
            check_eq("bp_2", got_q[2], {1'b0, 8'd8});
        end

        // Reset in the middle of an open frame
        send_beat(16'hFFFF, 1'b0, 1'b1);
        send_beat(16'hFFFF, 1'b0, 1'b1);
        pulse_reset();
        got_q.delete();
        send_beat(16'h00FF, 1'b1, 1'b1);
        drain();
        check_eq("rst_frame_n", got_q.size(), 1);
        check_eq("rst_frame_sum", got_q[0], {1'b0, 8'd8});

        // Random beats, modes, frame lengths and output backpressure
        ready_rand = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [N_IN-1:0] b;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            b = ($urandom_range(0, 1) == 0) ? 16'hFFFF : N_IN'($urandom);
            send_beat(b, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end
        ready_rand = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();
        check_eq("rand_out_count", n_out, n_push);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
